// File: rtl/mq_byteout_ctrl_if.sv
// Event-word input stream and code-byte output stream of the MQ byte-out sequencer.
// master: event producer / byte sink side; slave: the sequencer.
interface mq_byteout_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] ev_cnt;
   logic [1:0] ev_carry;
   logic [7:0] ev_byte0;
   logic [7:0] ev_byte1;
   logic       flush_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;

   modport master (
      output in_valid, ev_cnt, ev_carry, ev_byte0, ev_byte1, flush_in, out_ready,
      input  in_ready, out_valid, out_byte
   );
   modport slave (
      input  in_valid, ev_cnt, ev_carry, ev_byte0, ev_byte1, flush_in, out_ready,
      output in_ready, out_valid, out_byte
   );
endinterface

// File: rtl/mq_byteout_ctrl.sv
// MQ coder byte-out sequencer: B register, carry propagation, 0xFF stuffing flag, flush, output FIFO.
// Optional emitted-byte counter built when MQ_BYTE_CNT_EN is defined (byte_cnt tied to 0 otherwise).
module mq_byteout_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   mq_byteout_ctrl_if.slave bus,
   output logic             ff_stuff,
   output logic             done,
   output logic             err_carry,
   output logic [CNT_W-1:0] byte_cnt
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, EV1, FLUSH, DRAIN} state_t;

   state_t           state;
   logic [7:0]       b;
   logic             b_vld;
   logic             carry1_l;
   logic [7:0]       byte1_l;
   logic             flush_l;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;

   logic             fifo_full;
   logic             fifo_empty;
   logic             accept;
   logic             pop;
   logic             drain_done;
   logic             ev_fire;
   logic             ev_carry_sel;
   logic [7:0]       ev_byte_sel;
   logic             flush_fire;
   logic [7:0]       b_inc;
   logic             push;
   logic [7:0]       push_data;

   assign fifo_full     = (occ == OCC_W'(FIFO_DEPTH));
   assign fifo_empty    = (occ == '0);
   assign bus.in_ready  = (state == IDLE) && !fifo_full;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_byte  = mem[rd_ptr];
   assign ff_stuff      = b_vld && (b == 8'hFF);
   assign accept        = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign drain_done    = (state == DRAIN) && fifo_empty;

   // Select the byte event of this cycle and what (if anything) enters the FIFO
   always_comb begin
      ev_fire      = 1'b0;
      ev_carry_sel = 1'b0;
      ev_byte_sel  = 8'h00;
      flush_fire   = 1'b0;
      case (state)
         IDLE: begin
            ev_fire      = accept && (bus.ev_cnt != 2'd0);
            ev_carry_sel = bus.ev_carry[0];
            ev_byte_sel  = bus.ev_byte0;
         end
         EV1: begin
            ev_fire      = !fifo_full;
            ev_carry_sel = carry1_l;
            ev_byte_sel  = byte1_l;
         end
         FLUSH:   flush_fire = !fifo_full;
         default: ;
      endcase
      b_inc     = (ev_carry_sel && b_vld) ? b + 8'd1 : b;
      push      = (ev_fire && b_vld) || (flush_fire && b_vld && (b != 8'hFF));
      push_data = ev_fire ? b_inc : b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         b         <= 8'h00;
         b_vld     <= 1'b0;
         carry1_l  <= 1'b0;
         byte1_l   <= 8'h00;
         flush_l   <= 1'b0;
         done      <= 1'b0;
         err_carry <= 1'b0;
      end else begin
         done <= 1'b0;
         if (ev_fire) begin
            if (ev_carry_sel && b_vld && (b == 8'hFF)) err_carry <= 1'b1;
            b     <= ev_byte_sel;
            b_vld <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.ev_cnt[1]) begin
                     state    <= EV1;
                     carry1_l <= bus.ev_carry[1];
                     byte1_l  <= bus.ev_byte1;
                     flush_l  <= bus.flush_in;
                  end else if (bus.flush_in) begin
                     state <= FLUSH;
                  end
               end
            end
            EV1: begin
               if (!fifo_full) state <= flush_l ? FLUSH : IDLE;
            end
            FLUSH: begin
               // A trailing 0xFF is never emitted; the decoder implies it
               if (!fifo_full) begin
                  b_vld <= 1'b0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Push never bypasses a full FIFO, even when a pop happens in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      occ <= occ + OCC_W'(1);
         else if (pop && !push) occ <= occ - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

`ifdef MQ_BYTE_CNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (drain_done)       cnt <= '0;
      else if (pop && cnt != '1) cnt <= cnt + CNT_W'(1);
   end

   assign byte_cnt = cnt;
`else
   assign byte_cnt = '0;
`endif

endmodule

// File: tb/tb_mq_byteout_ctrl.sv
// Directed self-checking bench for mq_byteout_ctrl (FIFO_DEPTH=4).
module tb_mq_byteout_ctrl;
   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             ff_stuff;
   logic             done;
   logic             err_carry;
   logic [CNT_W-1:0] byte_cnt;
   logic [7:0]       got[$];
   int               checks;
   int               errors;

   mq_byteout_ctrl_if bus ();

   mq_byteout_ctrl #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ff_stuff  (ff_stuff),
      .done      (done),
      .err_carry (err_carry),
      .byte_cnt  (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sink: record every byte handed over at the next rising edge
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) got.push_back(bus.out_byte);
   end

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.ev_cnt   = 2'd0;
      bus.ev_carry = 2'd0;
      bus.ev_byte0 = 8'h00;
      bus.ev_byte1 = 8'h00;
      bus.flush_in = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] c, input logic [1:0] cy, input logic [7:0] b0,
                            input logic [7:0] b1, input logic f);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.ev_cnt   = c;
      bus.ev_carry = cy;
      bus.ev_byte0 = b0;
      bus.ev_byte1 = b1;
      bus.flush_in = f;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_word: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic wait_done(input string name, output logic [CNT_W-1:0] prev_cnt);
      int n;
      n = 0;
      prev_cnt = byte_cnt;
      while (done !== 1'b1 && n < 200) begin
         prev_cnt = byte_cnt;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done: done=%b after %0d cycles, required 1", name, done, n);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", bus.out_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b exp 0", done); end
      checks++; if (err_carry !== 1'b0) begin errors++; $display("FAIL reset err_carry: got %b exp 0", err_carry); end
      checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL reset byte_cnt: got %0d exp 0", byte_cnt); end
      checks++; if (ff_stuff !== 1'b0) begin errors++; $display("FAIL reset ff_stuff: got %b exp 0", ff_stuff); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0]       exp[3];
      logic [CNT_W-1:0] prev;
      logic [CNT_W-1:0] exp_cnt;
      exp = '{8'h12, 8'h34, 8'h56};
`ifdef MQ_BYTE_CNT_EN
      exp_cnt = CNT_W'(3);
`else
      exp_cnt = '0;
`endif
      got.delete();
      send_word(2'd1, 2'b00, 8'h12, 8'h00, 1'b0);
      send_word(2'd1, 2'b00, 8'h34, 8'h00, 1'b0);
      send_word(2'd1, 2'b00, 8'h56, 8'h00, 1'b1);
      wait_done("basic", prev);
      checks++; if (prev !== exp_cnt) begin errors++; $display("FAIL basic byte_cnt: got %0d exp %0d", prev, exp_cnt); end
      checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL basic byte_cnt clear: got %0d exp 0", byte_cnt); end
      checks++; if (got.size() !== 3) begin errors++; $display("FAIL basic count: got %0d bytes exp 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL basic byte%0d: got %h exp %h", i, got[i], exp[i]); end
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic done pulse width: got %b exp 0", done); end
   endtask

   task automatic test_empty_flush();
      logic [CNT_W-1:0] prev;
      got.delete();
      send_word(2'd0, 2'b00, 8'h00, 8'h00, 1'b1);
      wait_done("empty_flush", prev);
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL empty_flush count: got %0d bytes exp 0", got.size()); end
   endtask

   task automatic test_carry_and_ff();
      logic [7:0]       exp[2];
      logic [CNT_W-1:0] prev;
      exp = '{8'h80, 8'h20};
      got.delete();
      send_word(2'd1, 2'b00, 8'h7F, 8'h00, 1'b0);
      send_word(2'd1, 2'b01, 8'h20, 8'h00, 1'b0);
      checks++; if (ff_stuff !== 1'b0) begin errors++; $display("FAIL carry ff_stuff: got %b exp 0", ff_stuff); end
      send_word(2'd1, 2'b00, 8'hFF, 8'h00, 1'b0);
      checks++; if (ff_stuff !== 1'b1) begin errors++; $display("FAIL ff ff_stuff: got %b exp 1", ff_stuff); end
      send_word(2'd0, 2'b00, 8'h00, 8'h00, 1'b1);
      wait_done("ff_flush", prev);
      checks++; if (ff_stuff !== 1'b0) begin errors++; $display("FAIL ff_flush ff_stuff: got %b exp 0", ff_stuff); end
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL carry count: got %0d bytes exp 2", got.size()); end
      for (int i = 0; i < 2 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL carry byte%0d: got %h exp %h", i, got[i], exp[i]); end
      end
      checks++; if (err_carry !== 1'b0) begin errors++; $display("FAIL carry err_carry: got %b exp 0", err_carry); end
   endtask

   task automatic test_ev2();
      logic [7:0]       exp[3];
      logic [CNT_W-1:0] prev;
      exp = '{8'h11, 8'hAA, 8'hBB};
      got.delete();
      send_word(2'd1, 2'b00, 8'h11, 8'h00, 1'b0);
      send_word(2'd2, 2'b00, 8'hAA, 8'hBB, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ev2 in_ready low: got %b exp 0", bus.in_ready); end
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ev2 in_ready back: got %b exp 1", bus.in_ready); end
      send_word(2'd0, 2'b00, 8'h00, 8'h00, 1'b1);
      wait_done("ev2", prev);
      checks++; if (got.size() !== 3) begin errors++; $display("FAIL ev2 count: got %0d bytes exp 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL ev2 byte%0d: got %h exp %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [CNT_W-1:0] prev;
      got.delete();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_word(2'd1, 2'b00, 8'(i), 8'h00, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready full: got %b exp 0", bus.in_ready); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready held: got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid: got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_byte !== 8'h01) begin errors++; $display("FAIL bp out_byte stable: got %h exp 01", bus.out_byte); end
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL bp no pop: got %0d bytes exp 0", got.size()); end
      bus.out_ready = 1'b1;
      send_word(2'd1, 2'b00, 8'h06, 8'h00, 1'b1);
      wait_done("bp", prev);
      checks++; if (got.size() !== 6) begin errors++; $display("FAIL bp count: got %0d bytes exp 6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL bp byte%0d: got %h exp %h", i, got[i], 8'(i + 1)); end
      end
   endtask

   task automatic test_err_carry();
      logic [7:0]       exp[2];
      logic [CNT_W-1:0] prev;
      exp = '{8'h00, 8'h05};
      got.delete();
      send_word(2'd1, 2'b00, 8'hFF, 8'h00, 1'b0);
      send_word(2'd1, 2'b01, 8'h05, 8'h00, 1'b0);
      checks++; if (err_carry !== 1'b1) begin errors++; $display("FAIL err_carry set: got %b exp 1", err_carry); end
      send_word(2'd0, 2'b00, 8'h00, 8'h00, 1'b1);
      wait_done("err", prev);
      @(posedge clk); #1;
      checks++; if (err_carry !== 1'b1) begin errors++; $display("FAIL err_carry sticky: got %b exp 1", err_carry); end
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL err count: got %0d bytes exp 2", got.size()); end
      for (int i = 0; i < 2 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL err byte%0d: got %h exp %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid_drain();
      got.delete();
      bus.out_ready = 1'b0;
      send_word(2'd1, 2'b00, 8'h21, 8'h00, 1'b0);
      send_word(2'd1, 2'b00, 8'h22, 8'h00, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain out_valid: got %b exp 1", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain in_ready: got %b exp 0", bus.in_ready); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b exp 0", bus.out_valid); end
      checks++; if (err_carry !== 1'b0) begin errors++; $display("FAIL rst_mid err_carry: got %b exp 0", err_carry); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready: got %b exp 1", bus.in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL rst_mid discard: got %0d bytes exp 0", got.size()); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_empty_flush();
      test_carry_and_ff();
      test_ev2();
      test_backpressure();
      test_err_carry();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
